// File: rtl/neuron_mac_pkg.sv
// Shared definitions for the neuron multiply-accumulate stage: default widths,
// control levels and the FSM state encoding.
package neuron_mac_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_BITS_DEF  = 12;
  localparam int ACC_WIDTH_DEF  = 40;
  localparam int LEN_WIDTH_DEF  = 8;

  localparam logic HIGH    = 1'b1;
  localparam logic LOW     = 1'b0;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/neuron_mac_round_sat.sv
// Combinational round-half-up and saturate from the wide Q accumulator down to
// a DATA_WIDTH two's-complement result with FRAC_BITS fractional bits.
module neuron_mac_round_sat #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int ACC_WIDTH  = 40
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic        [DATA_WIDTH-1:0] result
);

  // One extra bit so adding the half-LSB can never overflow the accumulator.
  localparam logic signed [ACC_WIDTH:0] HALF    = (ACC_WIDTH+1)'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - (ACC_WIDTH+1)'(1);

  logic signed [ACC_WIDTH:0] sum;
  logic signed [ACC_WIDTH:0] shifted;

  always_comb begin
    sum     = $signed({acc[ACC_WIDTH-1], acc}) + HALF;
    shifted = sum >>> FRAC_BITS;
    result  = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Neuron dot-product engine: bias + sum(x*w) over len terms in a wide
// accumulator, then one rounding/saturation step to a Q3.12 result.
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] mac_out,
  output logic                  mac_rdy,
  output logic [1:0]            fsm_state
);

  // Handshake: a term is consumed on any rising edge in ACC where in_valid is
  // high; there is no back-pressure, so the source may stall for any length.

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  state_t                       state;
  logic [LEN_WIDTH-1:0]         len_q;
  logic [LEN_WIDTH-1:0]         count;
  logic [LEN_WIDTH-1:0]         next_count;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [PROD_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]        rounded;

  assign prod       = $signed(x_in) * $signed(w_in);
  assign prod_ext   = {{(ACC_WIDTH - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
  // Bias is aligned to the product's fractional point (2*FRAC_BITS).
  assign bias_ext   = {{(ACC_WIDTH - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} << FRAC_BITS;
  assign next_count = count + LEN_WIDTH'(1);
  assign fsm_state  = state;

  neuron_mac_round_sat #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_round_sat (
    .acc   (acc),
    .result(rounded)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      len_q   <= '0;
      count   <= '0;
      acc     <= '0;
      mac_out <= '0;
      mac_rdy <= LOW;
      busy    <= DISABLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            len_q   <= len;
            acc     <= bias_ext;
            count   <= '0;
            mac_rdy <= LOW;
            busy    <= ENABLE;
            state   <= (len != '0) ? ST_ACC : ST_ROUND;
          end
        end
        ST_ACC: begin
          if (in_valid) begin
            acc   <= acc + prod_ext;
            count <= next_count;
            if (next_count == len_q) begin
              state <= ST_ROUND;
            end
          end
        end
        ST_ROUND: begin
          mac_out <= rounded;
          mac_rdy <= HIGH;
          busy    <= DISABLE;
          state   <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: each scenario task drives a job and checks
// result, timing and status flags against hand-computed Q3.12 values.
module tb_neuron_mac;
  import neuron_mac_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic [15:0] bias;
  logic        in_valid;
  logic [15:0] x_in;
  logic [15:0] w_in;
  logic        busy;
  logic [15:0] mac_out;
  logic        mac_rdy;
  logic [1:0]  fsm_state;

  int checks;
  int errors;
  logic [15:0] exp_q[$];
  logic [15:0] exp_val;

  neuron_mac dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .bias     (bias),
    .in_valid (in_valid),
    .x_in     (x_in),
    .w_in     (w_in),
    .busy     (busy),
    .mac_out  (mac_out),
    .mac_rdy  (mac_rdy),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change on the falling edge, outputs are read 1 ns
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [7:0] l, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    bias  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drive_term(input logic [15:0] x, input logic [15:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = x;
    w_in     = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Reset state, then a len=0 job started on the first edge out of reset.
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++; if (mac_out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h exp 0000", mac_out); end
    checks++; if (mac_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", mac_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", fsm_state); end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    len   = 8'd0;
    bias  = 16'h0400;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL len0_busy got %b exp 1", busy); end
    checks++; if (mac_rdy !== 1'b0) begin errors++; $display("FAIL len0_rdy_early got %b exp 0", mac_rdy); end
    exp_q.push_back(16'h0400);
    tick();
    exp_val = exp_q.pop_front();
    checks++; if (mac_rdy !== 1'b1) begin errors++; $display("FAIL len0_rdy got %b exp 1", mac_rdy); end
    checks++; if (mac_out !== exp_val) begin errors++; $display("FAIL len0_out got %h exp %h", mac_out, exp_val); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy_done got %b exp 0", busy); end
  endtask

  // 1.0 * 1.0 with zero bias; the start from DONE must drop mac_rdy.
  task automatic test_single();
    drive_start(8'd1, 16'h0000);
    checks++; if (mac_rdy !== 1'b0) begin errors++; $display("FAIL single_rdy_drop got %b exp 0", mac_rdy); end
    drive_term(16'h1000, 16'h1000);
    checks++; if (mac_rdy !== 1'b0) begin errors++; $display("FAIL single_rdy_early got %b exp 0", mac_rdy); end
    exp_q.push_back(16'h1000);
    tick();
    exp_val = exp_q.pop_front();
    checks++; if (mac_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy got %b exp 1", mac_rdy); end
    checks++; if (mac_out !== exp_val) begin errors++; $display("FAIL single_out got %h exp %h", mac_out, exp_val); end
  endtask

  // 0.5 + (-1.0 * 2.0) = -1.5
  task automatic test_negative();
    drive_start(8'd1, 16'h0800);
    drive_term(16'hF000, 16'h2000);
    exp_q.push_back(16'hE800);
    tick();
    exp_val = exp_q.pop_front();
    checks++; if (mac_out !== exp_val) begin errors++; $display("FAIL negative_out got %h exp %h", mac_out, exp_val); end
  endtask

  // 4 * (7.0 * 4.0) = 112 saturates high; with x = -7.0 it saturates low.
  task automatic test_saturate();
    drive_start(8'd4, 16'h0000);
    for (int i = 0; i < 4; i++) drive_term(16'h7000, 16'h4000);
    exp_q.push_back(16'h7FFF);
    tick();
    exp_val = exp_q.pop_front();
    checks++; if (mac_out !== exp_val) begin errors++; $display("FAIL sat_pos_out got %h exp %h", mac_out, exp_val); end
    drive_start(8'd4, 16'h0000);
    for (int i = 0; i < 4; i++) drive_term(16'h9000, 16'h4000);
    exp_q.push_back(16'h8000);
    tick();
    exp_val = exp_q.pop_front();
    checks++; if (mac_out !== exp_val) begin errors++; $display("FAIL sat_neg_out got %h exp %h", mac_out, exp_val); end
  endtask

  // Exactly half an LSB rounds upward: +0.5 LSB -> 1, -0.5 LSB -> 0.
  task automatic test_rounding();
    drive_start(8'd1, 16'h0000);
    drive_term(16'h0001, 16'h0800);
    exp_q.push_back(16'h0001);
    tick();
    exp_val = exp_q.pop_front();
    checks++; if (mac_out !== exp_val) begin errors++; $display("FAIL round_pos_half got %h exp %h", mac_out, exp_val); end
    drive_start(8'd1, 16'h0000);
    drive_term(16'hFFFF, 16'h0800);
    exp_q.push_back(16'h0000);
    tick();
    exp_val = exp_q.pop_front();
    checks++; if (mac_out !== exp_val) begin errors++; $display("FAIL round_neg_half got %h exp %h", mac_out, exp_val); end
  endtask

  // Stalls between terms with start pulses while busy; a valid term on the
  // start edge and a term in DONE must both be ignored.
  task automatic test_gaps_busy();
    int gaps[3];
    gaps = '{0, 2, 5};
    @(negedge clk);
    start    = 1'b1;
    len      = 8'd3;
    bias     = 16'h0000;
    in_valid = 1'b1;
    x_in     = 16'h1000;
    w_in     = 16'h1000;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        @(negedge clk);
        start = 1'b1;
        len   = 8'd1;
        bias  = 16'h7000;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy term %0d got %b exp 1", i, busy); end
      end
      drive_term(16'h1000, 16'h1000);
    end
    checks++; if (mac_rdy !== 1'b0) begin errors++; $display("FAIL gap_rdy_early got %b exp 0", mac_rdy); end
    exp_q.push_back(16'h3000);
    tick();
    exp_val = exp_q.pop_front();
    checks++; if (mac_rdy !== 1'b1) begin errors++; $display("FAIL gap_rdy got %b exp 1", mac_rdy); end
    checks++; if (mac_out !== exp_val) begin errors++; $display("FAIL gap_out got %h exp %h", mac_out, exp_val); end
    drive_term(16'h7000, 16'h7000);
    tick();
    checks++; if (mac_out !== 16'h3000) begin errors++; $display("FAIL done_hold_out got %h exp 3000", mac_out); end
    checks++; if (mac_rdy !== 1'b1) begin errors++; $display("FAIL done_hold_rdy got %b exp 1", mac_rdy); end
    checks++; if (fsm_state !== ST_DONE) begin errors++; $display("FAIL done_state got %0d exp 3", fsm_state); end
  endtask

  // Reset after 2 of 4 terms abandons the job; the next job is clean.
  task automatic test_reset_mid();
    drive_start(8'd4, 16'h0000);
    drive_term(16'h1000, 16'h1000);
    drive_term(16'h1000, 16'h1000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    checks++; if (mac_out !== 16'h0000) begin errors++; $display("FAIL rst_mid_out got %h exp 0000", mac_out); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (mac_rdy !== 1'b0) begin errors++; $display("FAIL rst_mid_stale cycle %0d got %b exp 0", i, mac_rdy); end
    end
    drive_start(8'd1, 16'h0000);
    drive_term(16'h0800, 16'h1000);
    exp_q.push_back(16'h0800);
    tick();
    exp_val = exp_q.pop_front();
    checks++; if (mac_rdy !== 1'b1) begin errors++; $display("FAIL rst_new_rdy got %b exp 1", mac_rdy); end
    checks++; if (mac_out !== exp_val) begin errors++; $display("FAIL rst_new_out got %h exp %h", mac_out, exp_val); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    len      = 8'd0;
    bias     = 16'h0000;
    in_valid = 1'b0;
    x_in     = 16'h0000;
    w_in     = 16'h0000;
    test_reset();
    test_single();
    test_negative();
    test_saturate();
    test_rounding();
    test_gaps_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
